// File: rtl/fuzz_stim_pkg.sv
// fuzz_stim_pkg -- shared definitions for the fuzz stimulus sequencer.
//   STIM_W_DEFAULT / RESP_W_DEFAULT : default stimulus / response widths
//   W*_LSB / W*_MSB                 : positions of the DUT slices inside a stimulus vector
//   MISR_POLY                       : feedback polynomial used when FUZZ_STIM_SEQ_MISR_EN is defined
//   state_t                         : sequencer FSM states
package fuzz_stim_pkg;

  localparam int STIM_W_DEFAULT = 52;
  localparam int RESP_W_DEFAULT = 127;

  // Vector layout: {wire3[18:0], wire2[20:0], wire1[3:0], wire0[7:0]}
  localparam int W0_LSB = 0;
  localparam int W0_MSB = 7;
  localparam int W1_LSB = 8;
  localparam int W1_MSB = 11;
  localparam int W2_LSB = 12;
  localparam int W2_MSB = 32;
  localparam int W3_LSB = 33;
  localparam int W3_MSB = 51;

  // Taps 127,126 expressed in the shifted (Galois) form applied after the left shift.
  localparam logic [RESP_W_DEFAULT-1:0] MISR_POLY = 127'h3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_GAP   = 3'd2,
    ST_STALL = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // States in which a run is in progress and the DUT response is meaningful.
  function automatic logic is_busy(input state_t s);
    return (s inside {ST_APPLY, ST_GAP, ST_STALL, ST_DRAIN});
  endfunction

endpackage

// File: rtl/fuzz_stim_sequencer_fifo.sv
// fuzz_stim_fifo -- synchronous FIFO holding packed {vec, hold, gap, last} entries.
//   clk, rst    : clock, synchronous active-high reset (flushes the FIFO)
//   i_push      : write i_din (ignored when full)
//   i_pop       : discard the head entry (ignored when empty)
//   o_dout      : current head entry, valid while !o_empty
//   o_full      : DEPTH entries stored
//   o_empty     : no entries stored
//   o_count     : number of stored entries
// Flags derive from the registered count only, so a push into an empty FIFO
// becomes visible the next cycle and a pop from a full FIFO frees space only
// on the following cycle.
module fuzz_stim_fifo #(
  parameter int W     = 58,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  output logic [W-1:0]               o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fuzz_stim_sequencer.sv
// fuzz_stim_sequencer -- buffers stimulus vectors, applies each for a
// programmable number of cycles onto the fuzz DUT's input slices, and
// compacts the DUT response into a signature.
//   clk, rst                   : clock, synchronous active-high reset
//   start                      : begin a run (only honoured in IDLE with a non-empty FIFO)
//   in_valid/in_ready          : vector loader handshake
//   in_vec/in_hold/in_gap/in_last : vector, hold cycles (0 means 1), gap-after flag, last-of-run flag
//   wire3/wire2/wire1/wire0    : registered DUT stimulus slices
//   y                          : DUT response
//   busy, done                 : run in progress / one-cycle end-of-run pulse
//   underrun                   : sticky, FIFO ran dry mid-run
//   vec_count                  : vectors applied this run (saturating)
//   sig                        : response signature
// Build option FUZZ_STIM_SEQ_MISR_EN: when defined, sig is a MISR over y;
// otherwise sig simply holds the last captured y.
module fuzz_stim_sequencer
  import fuzz_stim_pkg::*;
#(
  parameter int STIM_W = STIM_W_DEFAULT,
  parameter int RESP_W = RESP_W_DEFAULT,
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [STIM_W-1:0] in_vec,
  input  logic [HOLD_W-1:0] in_hold,
  input  logic              in_gap,
  input  logic              in_last,
  output logic [18:0]       wire3,
  output logic [20:0]       wire2,
  output logic [3:0]        wire1,
  output logic [7:0]        wire0,
  input  logic [RESP_W-1:0] y,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic [15:0]       vec_count,
  output logic [RESP_W-1:0] sig
);

  localparam int ENT_W = STIM_W + HOLD_W + 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [ENT_W-1:0]  w_din;
  logic [ENT_W-1:0]  w_dout;
  logic [STIM_W-1:0] w_head_vec;
  logic [HOLD_W-1:0] w_head_hold;
  logic              w_head_gap;
  logic              w_head_last;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_first;
  logic              w_first_next;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_gap;
  logic              r_last;
  logic [STIM_W-1:0] r_drive;
  logic [15:0]       r_vec_count;
  logic              r_underrun;
  logic              r_cap_en;
  logic [RESP_W-1:0] r_sig;
  logic [RESP_W-1:0] w_sig_next;

  logic              w_entry;
  logic [HOLD_W-1:0] w_rem;
  logic              w_final;
  logic              w_cur_gap;
  logic              w_cur_last;
  logic              w_more;
  logic              w_start_run;

  assign w_din = {in_vec, in_hold, in_gap, in_last};
  assign {w_head_vec, w_head_hold, w_head_gap, w_head_last} = w_dout;
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;

  fuzz_stim_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // The first APPLY cycle of each vector pops the head and latches it; later
  // cycles of the same vector work from the latched copies.
  assign w_entry    = (r_state == ST_APPLY) && r_first;
  assign w_pop      = w_entry;
  assign w_rem      = w_entry ? ((w_head_hold == '0) ? HOLD_W'(1) : w_head_hold) : r_hold_cnt;
  assign w_final    = (w_rem == HOLD_W'(1));
  assign w_cur_gap  = w_entry ? w_head_gap  : r_gap;
  assign w_cur_last = w_entry ? w_head_last : r_last;
  // "Another vector is waiting" must not count the entry being popped right now.
  assign w_more     = (w_count - {{(CNT_W-1){1'b0}}, w_pop}) != '0;
  assign w_start_run = (r_state == ST_IDLE) && start && !w_empty;

  always_comb begin
    w_state_next = r_state;
    w_first_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_run) begin
          w_state_next = ST_APPLY;
          w_first_next = 1'b1;
        end
      end
      ST_APPLY: begin
        if (w_final) begin
          if (w_cur_gap) begin
            w_state_next = ST_GAP;
          end else if (w_cur_last) begin
            w_state_next = ST_DRAIN;
          end else if (w_more) begin
            w_state_next = ST_APPLY;
            w_first_next = 1'b1;
          end else begin
            w_state_next = ST_STALL;
          end
        end
      end
      ST_GAP: begin
        if (r_last) begin
          w_state_next = ST_DRAIN;
        end else if (!w_empty) begin
          w_state_next = ST_APPLY;
          w_first_next = 1'b1;
        end else begin
          w_state_next = ST_STALL;
        end
      end
      ST_STALL: begin
        if (!w_empty) begin
          w_state_next = ST_APPLY;
          w_first_next = 1'b1;
        end
      end
      ST_DRAIN: w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sig_next = r_sig;
    if (w_start_run) begin
      w_sig_next = '0;
    end else if (r_cap_en) begin
`ifdef FUZZ_STIM_SEQ_MISR_EN
      w_sig_next = {r_sig[RESP_W-2:0], 1'b0}
                 ^ (r_sig[RESP_W-1] ? MISR_POLY[RESP_W-1:0] : '0)
                 ^ y;
`else
      w_sig_next = y;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_first     <= 1'b0;
      r_hold_cnt  <= '0;
      r_gap       <= 1'b0;
      r_last      <= 1'b0;
      r_drive     <= '0;
      r_vec_count <= '0;
      r_underrun  <= 1'b0;
      r_cap_en    <= 1'b0;
      r_sig       <= '0;
    end else begin
      r_state  <= w_state_next;
      r_first  <= w_first_next;
      // Response lags the drive by one cycle, hence the registered enable.
      r_cap_en <= is_busy(r_state);
      r_sig    <= w_sig_next;

      if (r_state == ST_APPLY) begin
        r_hold_cnt <= w_rem - HOLD_W'(1);
        if (w_entry) begin
          r_drive <= w_head_vec;
          r_gap   <= w_head_gap;
          r_last  <= w_head_last;
          if (r_vec_count != 16'hFFFF) r_vec_count <= r_vec_count + 16'd1;
        end
      end else begin
        r_drive <= '0;
      end

      if (w_start_run) begin
        r_vec_count <= '0;
        r_underrun  <= 1'b0;
      end else if (r_state == ST_STALL) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign wire0     = r_drive[W0_MSB:W0_LSB];
  assign wire1     = r_drive[W1_MSB:W1_LSB];
  assign wire2     = r_drive[W2_MSB:W2_LSB];
  assign wire3     = r_drive[W3_MSB:W3_LSB];
  assign busy      = is_busy(r_state);
  assign done      = (r_state == ST_DONE);
  assign underrun  = r_underrun;
  assign vec_count = r_vec_count;
  assign sig       = r_sig;

endmodule

// File: tb/tb_fuzz_stim_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for fuzz_stim_sequencer: each run pushes its expected
// per-cycle slice/busy/done trace into a queue; a monitor compares on every
// falling edge while the queue holds entries. y is tied to 1, so the
// signature after k captures is 2^k-1 with the MISR, or 1 without it.
module tb_fuzz_stim_sequencer;

  localparam int STIM_W = 52;
  localparam int RESP_W = 127;
  localparam int DEPTH  = 8;
  localparam int HOLD_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [STIM_W-1:0] in_vec;
  logic [HOLD_W-1:0] in_hold;
  logic              in_gap;
  logic              in_last;
  logic [18:0]       wire3;
  logic [20:0]       wire2;
  logic [3:0]        wire1;
  logic [7:0]        wire0;
  logic [RESP_W-1:0] y;
  logic              busy;
  logic              done;
  logic              underrun;
  logic [15:0]       vec_count;
  logic [RESP_W-1:0] sig;

  int n_checks = 0;
  int n_errors = 0;
  int trace_idx = 0;

  typedef struct packed {
    logic [STIM_W-1:0] s;
    logic              b;
    logic              d;
  } obs_t;

  obs_t exp_q[$];

  always #5 clk = ~clk;

  fuzz_stim_sequencer #(
    .STIM_W (STIM_W),
    .RESP_W (RESP_W),
    .DEPTH  (DEPTH),
    .HOLD_W (HOLD_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .in_hold   (in_hold),
    .in_gap    (in_gap),
    .in_last   (in_last),
    .wire3     (wire3),
    .wire2     (wire2),
    .wire1     (wire1),
    .wire0     (wire0),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun),
    .vec_count (vec_count),
    .sig       (sig)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [STIM_W-1:0] vec_of(input int i);
    logic [3:0] hi;
    hi = 4'(i + 1);
    return {hi, 12'hC3A, 36'(i * 37 + 5)};
  endfunction

  function automatic logic [RESP_W-1:0] sig_after(input int k);
`ifdef FUZZ_STIM_SEQ_MISR_EN
    logic [RESP_W-1:0] one;
    one = 1;
    return (one << k) - 1;
`else
    return (k > 0) ? 127'h1 : 127'h0;
`endif
  endfunction

  task automatic exp_add(input logic [STIM_W-1:0] s, input logic b, input logic d);
    exp_q.push_back({s, b, d});
  endtask

  task automatic exp_rep(input logic [STIM_W-1:0] s, input logic b, input logic d, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({s, b, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input int i, input logic [HOLD_W-1:0] h, input logic g, input logic l);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_vec   = vec_of(i);
    in_hold  = h;
    in_gap   = g;
    in_last  = l;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout: vector %0d got in_ready=0 expected 1 within 50 cycles", i);
    end
  endtask

  task automatic wait_trace();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(posedge clk);
      c++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL trace_timeout: %0d entries left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: one comparison per cycle while an expected trace is pending.
  initial begin : monitor
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {wire3, wire2, wire1, wire0, busy, done};
        chk($sformatf("trace[%0d] {slices,busy,done}", trace_idx), 128'(a), 128'(e));
        trace_idx++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_vec = '0;
    in_hold = '0; in_gap = 1'b0; in_last = 1'b0; y = 127'h1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_slices", 128'({wire3, wire2, wire1, wire0}), 128'(0));
    chk("reset_vec_count", 128'(vec_count), 128'(0));
    chk("reset_sig", 128'(sig), 128'(0));
    tick();

    // Run 1: three hold-1 vectors back to back.
    push_vec(0, 4'd1, 1'b0, 1'b0);
    push_vec(1, 4'd1, 1'b0, 1'b0);
    push_vec(2, 4'd1, 1'b0, 1'b1);
    start = 1'b1;
    exp_add('0, 0, 0); exp_add('0, 1, 0);
    exp_add(vec_of(0), 1, 0); exp_add(vec_of(1), 1, 0); exp_add(vec_of(2), 1, 0);
    exp_add('0, 0, 1); exp_add('0, 0, 0);
    tick(); start = 1'b0;
    wait_trace();
    chk("r1_vec_count", 128'(vec_count), 128'(3));
    chk("r1_underrun", 128'(underrun), 128'(0));
    chk("r1_sig", 128'(sig), 128'(sig_after(4)));

    // Run 2: hold 0 treated as 1, then hold 5 with a gap cycle.
    push_vec(3, 4'd0, 1'b0, 1'b0);
    push_vec(4, 4'd5, 1'b1, 1'b1);
    start = 1'b1;
    exp_add('0, 0, 0); exp_add('0, 1, 0);
    exp_add(vec_of(3), 1, 0); exp_rep(vec_of(4), 1, 0, 5);
    exp_add('0, 1, 0); exp_add('0, 0, 1); exp_add('0, 0, 0);
    tick(); start = 1'b0;
    wait_trace();
    chk("r2_vec_count", 128'(vec_count), 128'(2));
    chk("r2_sig", 128'(sig), 128'(sig_after(8)));

    // Run 3: FIFO runs dry; next vector arrives 4 cycles after start.
    push_vec(5, 4'd1, 1'b0, 1'b0);
    start = 1'b1;
    exp_add('0, 0, 0); exp_add('0, 1, 0); exp_add(vec_of(5), 1, 0);
    exp_rep('0, 1, 0, 4); exp_add(vec_of(6), 1, 0);
    exp_add('0, 0, 1); exp_add('0, 0, 0);
    tick(); start = 1'b0;
    tick(); tick(); tick();
    push_vec(6, 4'd1, 1'b0, 1'b1);
    wait_trace();
    chk("r3_underrun", 128'(underrun), 128'(1));
    chk("r3_vec_count", 128'(vec_count), 128'(2));
    chk("r3_sig", 128'(sig), 128'(sig_after(7)));

    // Run 4: two-vector run, signature after three captures; start clears state.
    push_vec(7, 4'd1, 1'b0, 1'b0);
    push_vec(8, 4'd1, 1'b0, 1'b1);
    start = 1'b1;
    exp_add('0, 0, 0); exp_add('0, 1, 0);
    exp_add(vec_of(7), 1, 0); exp_add(vec_of(8), 1, 0);
    exp_add('0, 0, 1); exp_add('0, 0, 0);
    tick(); start = 1'b0;
    tick();
    @(negedge clk);
    chk("r4_sig_cleared", 128'(sig), 128'(0));
    wait_trace();
    chk("r4_sig", 128'(sig), 128'(sig_after(3)));
    chk("r4_underrun_cleared", 128'(underrun), 128'(0));
    chk("r4_vec_count", 128'(vec_count), 128'(2));

    // Run 5: fill the FIFO, the ninth push waits for the first pop.
    for (int i = 0; i < 8; i++) push_vec(9 + i, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("r5_ready_full", 128'(in_ready), 128'(0));
    tick();
    in_valid = 1'b1; in_vec = vec_of(17); in_hold = 4'd1; in_gap = 1'b0; in_last = 1'b1;
    start = 1'b1;
    exp_add('0, 0, 0); exp_add('0, 1, 0);
    for (int i = 0; i < 9; i++) exp_add(vec_of(9 + i), 1, 0);
    exp_add('0, 0, 1); exp_add('0, 0, 0);
    @(negedge clk);
    chk("r5_ready_at_start", 128'(in_ready), 128'(0));
    tick(); start = 1'b0;
    @(negedge clk);
    chk("r5_ready_during_pop", 128'(in_ready), 128'(0));
    tick();
    @(negedge clk);
    chk("r5_ready_after_pop", 128'(in_ready), 128'(1));
    tick(); in_valid = 1'b0;
    wait_trace();
    chk("r5_vec_count", 128'(vec_count), 128'(9));
    chk("r5_sig", 128'(sig), 128'(sig_after(10)));

    // Run 6: reset during APPLY, start ignored while empty, then a fresh run.
    push_vec(18, 4'd3, 1'b0, 1'b0);
    push_vec(19, 4'd3, 1'b0, 1'b1);
    start = 1'b1;
    exp_add('0, 0, 0); exp_add('0, 1, 0); exp_add(vec_of(18), 1, 0);
    tick(); start = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("r6_rst_busy", 128'(busy), 128'(0));
    chk("r6_rst_slices", 128'({wire3, wire2, wire1, wire0}), 128'(0));
    chk("r6_rst_vec_count", 128'(vec_count), 128'(0));
    chk("r6_rst_sig", 128'(sig), 128'(0));
    chk("r6_rst_in_ready", 128'(in_ready), 128'(1));
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    @(negedge clk);
    chk("r6_start_ignored_busy", 128'(busy), 128'(0));
    tick(); tick();
    push_vec(20, 4'd2, 1'b0, 1'b1);
    start = 1'b1;
    exp_add('0, 0, 0); exp_add('0, 1, 0);
    exp_add(vec_of(20), 1, 0); exp_add(vec_of(20), 1, 0);
    exp_add('0, 0, 1); exp_add('0, 0, 0);
    tick(); start = 1'b0;
    wait_trace();
    chk("r6_vec_count", 128'(vec_count), 128'(1));
    chk("r6_sig", 128'(sig), 128'(sig_after(3)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
